// File: rtl/thr_cfg_pkg.sv
// Shared types and constants for the threshold configuration controller.
package thr_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_VAL,
    ST_CHK,
    ST_ACK
  } state_t;

  localparam logic [7:0] HDR_BYTE   = 8'h55;
  localparam logic [7:0] CMD_RED    = 8'h01;
  localparam logic [7:0] CMD_GREEN  = 8'h02;
  localparam logic [7:0] CMD_BLUE   = 8'h03;
  localparam logic [7:0] CMD_COMMIT = 8'h10;

  // True when the command is known and its value fits the target field.
  function automatic logic cmd_val_ok(input logic [7:0] cmd, input logic [7:0] val);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_RED:    ok = (val <= 8'd31);
      CMD_GREEN:  ok = (val <= 8'd63);
      CMD_BLUE:   ok = (val <= 8'd31);
      CMD_COMMIT: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/thr_cfg_ctrl_vs_edge_det.sv
// Registers a synchronous level and flags its rising edge.
module vs_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  // One-cycle delayed copy of the input level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig && !sig_d;

endmodule

// File: rtl/thr_cfg_ctrl.sv
// UART-driven threshold configuration: packet parser, shadow registers,
// frame-synchronous commit to the live thresholds and ACK/NAK response.
module thr_cfg_ctrl
  import thr_cfg_pkg::*;
#(
  parameter logic [4:0]  RED_DEFAULT    = 5'd10,
  parameter logic [5:0]  GREEN_DEFAULT  = 6'd20,
  parameter logic [4:0]  BLUE_DEFAULT   = 5'd10,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
  parameter logic [7:0]  ACK_BYTE       = 8'hAC,
  parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       in_vs,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [4:0] thr_red,
  output logic [5:0] thr_green,
  output logic [4:0] thr_blue,
  output logic       commit_pending
);

  state_t      state, state_next;
  logic [7:0]  cmd_q, val_q;
  logic [4:0]  sh_red, sh_blue;
  logic [5:0]  sh_green;
  logic [31:0] tmo_cnt;
  logic        frame_start;
  logic        cmd_we, val_we, resp_we, tmo_hit, tx_done;
  logic        pkt_ok, shadow_we, cnt_clr;

  vs_edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (in_vs),
    .rise (frame_start)
  );

  // Packet is accepted when the checksum byte matches and cmd/value are legal.
  always_comb begin
    pkt_ok    = (rx_data == (cmd_q ^ val_q)) && cmd_val_ok(cmd_q, val_q);
    shadow_we = resp_we && pkt_ok;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    cmd_we     = 1'b0;
    val_we     = 1'b0;
    resp_we    = 1'b0;
    tmo_hit    = 1'b0;
    tx_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && rx_data == HDR_BYTE) state_next = ST_CMD;
      end
      ST_CMD: begin
        if (rx_valid) begin
          cmd_we     = 1'b1;
          state_next = ST_VAL;
        end else if (tmo_cnt == TIMEOUT_CYCLES - 32'd1) begin
          tmo_hit    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_VAL: begin
        if (rx_valid) begin
          val_we     = 1'b1;
          state_next = ST_CHK;
        end else if (tmo_cnt == TIMEOUT_CYCLES - 32'd1) begin
          tmo_hit    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          resp_we    = 1'b1;
          state_next = ST_ACK;
        end else if (tmo_cnt == TIMEOUT_CYCLES - 32'd1) begin
          tmo_hit    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (tx_valid && tx_ready) begin
          tx_done    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Inter-byte timeout counter; only runs while a packet is partially received.
  always_comb begin
    cnt_clr = (state == ST_IDLE) || (state == ST_ACK) || rx_valid || tmo_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tmo_cnt <= '0;
    else if (cnt_clr) tmo_cnt <= '0;
    else              tmo_cnt <= tmo_cnt + 32'd1;
  end

  // Latch command and value bytes of the packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
      val_q <= '0;
    end else begin
      if (cmd_we) cmd_q <= rx_data;
      if (val_we) val_q <= rx_data;
    end
  end

  // Shadow registers take accepted writes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_red   <= RED_DEFAULT;
      sh_green <= GREEN_DEFAULT;
      sh_blue  <= BLUE_DEFAULT;
    end else if (shadow_we) begin
      case (cmd_q)
        CMD_RED:   sh_red   <= val_q[4:0];
        CMD_GREEN: sh_green <= val_q[5:0];
        CMD_BLUE:  sh_blue  <= val_q[4:0];
        default: ;
      endcase
    end
  end

  // Frame-start commit of the shadow; a write landing on the same edge
  // keeps pending set so the new value waits for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_red        <= RED_DEFAULT;
      thr_green      <= GREEN_DEFAULT;
      thr_blue       <= BLUE_DEFAULT;
      commit_pending <= 1'b0;
    end else begin
      if (frame_start && commit_pending) begin
        thr_red   <= sh_red;
        thr_green <= sh_green;
        thr_blue  <= sh_blue;
      end
      if (shadow_we)                           commit_pending <= 1'b1;
      else if (frame_start && commit_pending)  commit_pending <= 1'b0;
    end
  end

  // Response byte: loaded on the checksum byte, held until the TX side accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (resp_we) begin
      tx_data  <= pkt_ok ? ACK_BYTE : NAK_BYTE;
      tx_valid <= 1'b1;
    end else if (tx_done) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: doc/thr_cfg_ctrl.md
Name: thr_cfg_ctrl

Overview:
- Runtime configuration controller for the RGB565 binarisation threshold stage in the LCD path.
- Parses threshold-write packets from the UART RX byte stream and holds them in shadow registers.
- Commits shadow values to the live threshold outputs only at frame start (rising edge of the video VS), so one frame is never binarised with mixed thresholds.
- Returns a one-byte ACK/NAK per packet over the UART TX handshake.

Parameters:
- RED_DEFAULT, 5'd10, reset value of red max threshold (0-31)
- GREEN_DEFAULT, 6'd20, reset value of green max threshold (0-63)
- BLUE_DEFAULT, 5'd10, reset value of blue max threshold (0-31)
- TIMEOUT_CYCLES, 32'd5_000_000, max clk cycles allowed between bytes inside a packet
- ACK_BYTE, 8'hAC, response for an accepted packet
- NAK_BYTE, 8'hEE, response for a rejected packet

Ports:
- clk  in  1  system/pixel clock; all logic is on its rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- in_vs  in  1  video vertical sync, synchronous to clk
- tx_data  out  8  response byte
- tx_valid  out  1  response valid; held until accepted
- tx_ready  in  1  UART TX accepts tx_data when tx_valid && tx_ready
- thr_red  out  5  live red max threshold
- thr_green  out  6  live green max threshold
- thr_blue  out  5  live blue max threshold
- commit_pending  out  1  shadow holds values not yet committed

Behaviour:
- Reset: thr_* and shadow registers = *_DEFAULT; tx_valid=0; tx_data=0; commit_pending=0; FSM=IDLE; timeout counter=0; vs_d=0.
- Packet format: 0x55, CMD, VAL, CHK, with CHK = CMD ^ VAL.
- Commands:
  - CMD 0x01 writes red; VAL must be ≤31.
  - CMD 0x02 writes green; VAL must be ≤63.
  - CMD 0x03 writes blue; VAL must be ≤31.
  - CMD 0x10 forces commit_pending=1 and ignores VAL.
- FSM states: IDLE, CMD, VAL, CHK, ACK.
  - IDLE: on rx_valid with byte 0x55 go to CMD; any other byte is dropped and FSM stays in IDLE.
  - CMD: latch the byte and go to VAL.
  - VAL: latch the byte and go to CHK.
  - CHK: on rx_valid, go to ACK in all cases.
    - A packet is valid when the checksum matches, CMD is known and VAL is in range.
    - If valid: update the targeted shadow register in the same cycle, set commit_pending=1, tx_data=ACK_BYTE.
    - Else: shadow is unchanged, tx_data=NAK_BYTE.
    - tx_valid=1 from the next cycle.
  - ACK: hold tx_valid and tx_data. On tx_valid && tx_ready, clear tx_valid and go to IDLE.
  - rx_valid bytes arriving in ACK are dropped.
- Timeout:
  - Counter clears on every accepted rx_valid and while in IDLE or ACK; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES-1 in CMD/VAL/CHK, go to IDLE with no response and no shadow change.
- Commit:
  - vs_d registers in_vs; a frame start is in_vs && !vs_d.
  - On a frame start with commit_pending=1: thr_* <= shadow (visible the next cycle) and commit_pending <= 0.
- Simultaneous events: a shadow write in the same cycle as a frame start is not committed that frame. thr_* take the old shadow value and commit_pending stays 1 for the next frame.
- thr_* change only at a frame start; they never change mid-frame.
- Latency: ACK appears 1 cycle after the CHK byte strobe. Worst-case threshold latency is one full frame.
- Async reset mid-packet or mid-ACK returns everything to reset values immediately; the partial packet is discarded.

Decomposition:
- Package thr_cfg_pkg holds:
  - the FSM state enum;
  - the constants HDR_BYTE=8'h55, CMD_RED=8'h01, CMD_GREEN=8'h02, CMD_BLUE=8'h03, CMD_COMMIT=8'h10.
- Sub-module: none required. An optional vs_edge_det (register plus rising detect) may be factored out for reuse.

Test Plan:
- Reset values: after rst release, idle for 2 frames -> thr_red=10, thr_green=20, thr_blue=10, tx_valid=0.
- Green write: bytes 55 02 2A 28 -> tx_data=AC, commit_pending=1, thr_green still 20 until the next in_vs rise, then 42; commit_pending=0.
- Bad input NAKs: bytes 55 01 3F 3E (red 63 out of range) -> tx_data=EE, shadow and thr_red unchanged. Same for bad CHK: 55 03 05 00 -> EE.
- Timeout: bytes 55 01, then silence for TIMEOUT_CYCLES (set to 100 in the bench) -> FSM back to IDLE, no tx_valid. A following 55 01 05 04 -> AC.
- Coincident write and frame start: last byte of 55 03 07 04 strobed in the same cycle as an in_vs rise -> thr_blue unchanged this frame, commit_pending=1, thr_blue=7 after the next rise.
- Backpressure and reset: tx_ready held low for 50 cycles -> tx_valid/tx_data stable and extra rx bytes dropped. Asserting rst during CHK -> immediate return to default values.
